// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
//   Shared types and helpers for the N x N, K-in-a-row tic-tac-toe controller.
//   - state_t           : controller FSM states
//   - cell_idx()        : flat board bit index for (row, col)
//   - TTT_PARAMS_OK()   : parameter legality test (N in 3..8, K in 3..N)
//   No ports (package).
// ----------------------------------------------------------------------------
`ifndef TTT_PKG_SV
`define TTT_PKG_SV

`define TTT_PARAMS_OK(n, k) (((n) >= 3) && ((n) <= 8) && ((k) >= 3) && ((k) <= (n)))

package ttt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Board bit for a cell: rows are laid out one after another, row 0 first.
   function automatic int cell_idx(input int row, input int col, input int n);
      return row * n + col;
   endfunction

endpackage

`endif

// File: rtl/ttt_game_ctrl_chk.sv
// ----------------------------------------------------------------------------
// ttt_game_ctrl_chk
//   Property checker bound into ttt_game_ctrl. Observes only; drives nothing.
//   Ports:
//     clk_i, rst_ni           clock and async active-low reset
//     board_x_i, board_o_i    occupancy boards
//     win_x_i, win_o_i,
//     draw_i, game_over_i     result flags
// ----------------------------------------------------------------------------
module ttt_game_ctrl_chk #(
   parameter int N = 3,
   parameter int K = N
) (
   input logic           clk_i,
   input logic           rst_ni,
   input logic [N*N-1:0] board_x_i,
   input logic [N*N-1:0] board_o_i,
   input logic           win_x_i,
   input logic           win_o_i,
   input logic           draw_i,
   input logic           game_over_i
);

   localparam bit PARAMS_OK = `TTT_PARAMS_OK(N, K);

   a_params_legal : assert property (@(posedge clk_i) PARAMS_OK);

   // A cell can never hold both stones.
   a_disjoint : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (board_x_i & board_o_i) == '0);

   // Only the mover can newly win, so both sides never win together.
   a_one_winner : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(win_x_i && win_o_i));

   a_game_over : assert property (@(posedge clk_i) disable iff (!rst_ni)
      game_over_i == (win_x_i || win_o_i || draw_i));

endmodule

// File: rtl/ttt_line_detect.sv
// ----------------------------------------------------------------------------
// ttt_line_detect
//   Combinational K-in-a-row detector for one side's N x N occupancy board.
//   Ports:
//     board_i  in  N*N  occupancy, bit row*N+col
//     line_o   out 1    1 when any K consecutive cells are occupied along a
//                       row, column, diagonal (down-right) or anti-diagonal
//                       (down-left)
// ----------------------------------------------------------------------------
module ttt_line_detect
   import ttt_pkg::*;
#(
   parameter int N = 3,
   parameter int K = N
) (
   input  logic [N*N-1:0] board_i,
   output logic           line_o
);

   localparam int CELLS = N * N;
   localparam int IW    = $clog2(CELLS);
   // Number of start positions for a K-long segment along one board side.
   localparam int SPAN  = N - K + 1;

   // True when the K cells starting at (r0, c0) and stepping (dr, dc) are all set.
   function automatic logic line_at(input logic [CELLS-1:0] b,
                                    input int r0, input int c0,
                                    input int dr, input int dc);
      logic all_s;
      all_s = 1'b1;
      for (int i = 0; i < K; i++) begin
         all_s = all_s & b[IW'(cell_idx(r0 + i * dr, c0 + i * dc, N))];
      end
      return all_s;
   endfunction

   logic [N*SPAN-1:0]    row_hit_s;
   logic [N*SPAN-1:0]    col_hit_s;
   logic [SPAN*SPAN-1:0] diag_hit_s;
   logic [SPAN*SPAN-1:0] anti_hit_s;

   // Rows and columns: every line index, every start offset along it.
   for (genvar r = 0; r < N; r++) begin : g_line
      for (genvar c = 0; c < SPAN; c++) begin : g_start
         assign row_hit_s[r*SPAN + c] = line_at(board_i, r, c, 1'b0, 1'b1);
         assign col_hit_s[r*SPAN + c] = line_at(board_i, c, r, 1'b1, 1'b0);
      end
   end

   // Diagonals: top-left corner of each K x K window; the anti-diagonal
   // starts at the window's top-right corner and walks down-left.
   for (genvar r = 0; r < SPAN; r++) begin : g_diag_r
      for (genvar c = 0; c < SPAN; c++) begin : g_diag_c
         assign diag_hit_s[r*SPAN + c] = line_at(board_i, r, c, 1, 1);
         assign anti_hit_s[r*SPAN + c] = line_at(board_i, r, c + K - 1, 1, -1);
      end
   end

   assign line_o = |{row_hit_s, col_hit_s, diag_hit_s, anti_hit_s};

endmodule

// File: rtl/ttt_game_ctrl.sv
// ----------------------------------------------------------------------------
// ttt_game_ctrl
//   Sequential N x N, K-in-a-row tic-tac-toe controller. Holds the board,
//   alternates turns (X first), accepts moves over valid/ready, rejects
//   illegal moves and reports win / draw / game over.
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     start                 clear board and flags, X to move, next cycle
//     move_valid/ready      move handshake; accepted when both high
//     move_row, move_col    move coordinates, 0 = top / left
//     turn_o                side to move: 0 = X, 1 = O
//     board_x, board_o      occupancy, bit row*N+col
//     illegal               one-cycle pulse on a rejected move
//     win_x, win_o, draw    sticky results until start
//     game_over             win_x | win_o | draw
// ----------------------------------------------------------------------------
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter int N = 3,
   parameter int K = N
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 move_valid,
   output logic                 move_ready,
   input  logic [$clog2(N)-1:0] move_row,
   input  logic [$clog2(N)-1:0] move_col,
   output logic                 turn_o,
   output logic [N*N-1:0]       board_x,
   output logic [N*N-1:0]       board_o,
   output logic                 illegal,
   output logic                 win_x,
   output logic                 win_o,
   output logic                 draw,
   output logic                 game_over
);

   localparam int CELLS = N * N;

   state_t           state_q, state_d;
   logic [CELLS-1:0] board_x_q, board_x_d;
   logic [CELLS-1:0] board_o_q, board_o_d;
   logic             turn_q, turn_d;
   logic             illegal_q, illegal_d;
   logic             win_x_q, win_x_d;
   logic             win_o_q, win_o_d;
   logic             draw_q, draw_d;
   logic             game_over_q, game_over_d;

   logic             ready_s;
   logic             accept_s;
   logic             rc_ok_s;
   logic             legal_s;
   logic             line_s;
   logic             full_s;
   logic [CELLS-1:0] move_mask_s;
   logic [CELLS-1:0] mover_board_s;

   // A pending restart wins over a move in the same cycle, so drop ready.
   assign ready_s  = (state_q == TURN) && !start;
   assign accept_s = move_valid && ready_s;

   // Decode the presented coordinates into a one-hot cell mask (zero if off-board).
   always_comb begin
      rc_ok_s = (int'(move_row) < N) && (int'(move_col) < N);
      for (int i = 0; i < CELLS; i++) begin
         move_mask_s[i] = rc_ok_s && (i == cell_idx(int'(move_row), int'(move_col), N));
      end
   end

   assign legal_s = rc_ok_s && ((move_mask_s & (board_x_q | board_o_q)) == '0);

   // turn_q still names the mover while in CHECK, so only that side is examined.
   assign mover_board_s = turn_q ? board_o_q : board_x_q;
   assign full_s        = &(board_x_q | board_o_q);

   ttt_line_detect #(
      .N (N),
      .K (K)
   ) u_line_detect (
      .board_i (mover_board_s),
      .line_o  (line_s)
   );

   // Next-state logic for the game FSM, board and result flags.
   always_comb begin
      state_d     = state_q;
      board_x_d   = board_x_q;
      board_o_d   = board_o_q;
      turn_d      = turn_q;
      illegal_d   = 1'b0;
      win_x_d     = win_x_q;
      win_o_d     = win_o_q;
      draw_d      = draw_q;
      game_over_d = game_over_q;

      if (start) begin
         state_d     = TURN;
         board_x_d   = '0;
         board_o_d   = '0;
         turn_d      = 1'b0;
         win_x_d     = 1'b0;
         win_o_d     = 1'b0;
         draw_d      = 1'b0;
         game_over_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            TURN: begin
               if (accept_s && legal_s) begin
                  if (turn_q) begin
                     board_o_d = board_o_q | move_mask_s;
                  end else begin
                     board_x_d = board_x_q | move_mask_s;
                  end
                  state_d = CHECK;
               end else if (accept_s) begin
                  // Rejected: same player stays on move and may retry at once.
                  illegal_d = 1'b1;
               end else begin
                  state_d = TURN;
               end
            end
            CHECK: begin
               if (line_s) begin
                  if (turn_q) begin
                     win_o_d = 1'b1;
                  end else begin
                     win_x_d = 1'b1;
                  end
                  game_over_d = 1'b1;
                  state_d     = DONE;
               end else if (full_s) begin
                  // Checked after the line test so a win on the last cell is not a draw.
                  draw_d      = 1'b1;
                  game_over_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = TURN;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         board_x_q   <= '0;
         board_o_q   <= '0;
         turn_q      <= 1'b0;
         illegal_q   <= 1'b0;
         win_x_q     <= 1'b0;
         win_o_q     <= 1'b0;
         draw_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_x_q   <= board_x_d;
         board_o_q   <= board_o_d;
         turn_q      <= turn_d;
         illegal_q   <= illegal_d;
         win_x_q     <= win_x_d;
         win_o_q     <= win_o_d;
         draw_q      <= draw_d;
         game_over_q <= game_over_d;
      end
   end

   assign move_ready = ready_s;
   assign turn_o     = turn_q;
   assign board_x    = board_x_q;
   assign board_o    = board_o_q;
   assign illegal    = illegal_q;
   assign win_x      = win_x_q;
   assign win_o      = win_o_q;
   assign draw       = draw_q;
   assign game_over  = game_over_q;

   ttt_game_ctrl_chk #(
      .N (N),
      .K (K)
   ) u_chk (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .board_x_i   (board_x_q),
      .board_o_i   (board_o_q),
      .win_x_i     (win_x_q),
      .win_o_i     (win_o_q),
      .draw_i      (draw_q),
      .game_over_i (game_over_q)
   );

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ttt_game_ctrl
//   Drives a 3x3 instance and a 4x4 (K=3) instance from one shared stimulus
//   bus. Each table entry is one clock: inputs applied before the edge,
//   inputs released after it, then the selected instance's outputs compared.
//   Expected flags are packed {ready, turn, illegal, win_x, win_o, draw, go}.
// ----------------------------------------------------------------------------
module tb_ttt_game_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       move_valid;
   logic [1:0] move_row;
   logic [1:0] move_col;

   logic       rdy3, turn3, ill3, wx3, wo3, dr3, go3;
   logic [8:0] bx3, bo3;
   logic       rdy4, turn4, ill4, wx4, wo4, dr4, go4;
   logic [15:0] bx4, bo4;

   ttt_game_ctrl #(.N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
      .move_ready(rdy3), .move_row(move_row), .move_col(move_col),
      .turn_o(turn3), .board_x(bx3), .board_o(bo3), .illegal(ill3),
      .win_x(wx3), .win_o(wo3), .draw(dr3), .game_over(go3)
   );

   ttt_game_ctrl #(.N(4), .K(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
      .move_ready(rdy4), .move_row(move_row), .move_col(move_col),
      .turn_o(turn4), .board_x(bx4), .board_o(bo4), .illegal(ill4),
      .win_x(wx4), .win_o(wo4), .draw(dr4), .game_over(go4)
   );

   typedef struct {
      bit          d;      // 0: 3x3 instance, 1: 4x4 instance
      bit          st;
      bit          v;
      logic [1:0]  r;
      logic [1:0]  c;
      logic [6:0]  f;      // {ready, turn, illegal, win_x, win_o, draw, go}
      logic [15:0] bx;
      logic [15:0] bo;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input bit d, input bit st, input bit v,
                               input logic [1:0] r, input logic [1:0] c,
                               input logic [6:0] f,
                               input logic [15:0] bx, input logic [15:0] bo);
      vec_t t;
      t.d = d; t.st = st; t.v = v; t.r = r; t.c = c;
      t.f = f; t.bx = bx; t.bo = bo;
      return t;
   endfunction

   function automatic logic [38:0] actual(input bit d);
      if (d)
         return {rdy4, turn4, ill4, wx4, wo4, dr4, go4, bx4, bo4};
      else
         return {rdy3, turn3, ill3, wx3, wo3, dr3, go3, 7'd0, bx3, 7'd0, bo3};
   endfunction

   task automatic check(input string name, input logic [38:0] got, input logic [38:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic run_vec(input vec_t t, input string name);
      @(negedge clk);
      start      = t.st;
      move_valid = t.v;
      move_row   = t.r;
      move_col   = t.c;
      @(posedge clk);
      #1;
      start      = 1'b0;
      move_valid = 1'b0;
      #1;
      check(name, actual(t.d), {t.f, t.bx, t.bo});
   endtask

   initial begin
      // ---------------- stimulus table ----------------
      // In IDLE a presented move is ignored
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b0000000,16'h000,16'h000));
      // Row win for X
      tbl.push_back(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b0000000,16'h001,16'h000));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h001,16'h000));
      tbl.push_back(mk(0,0,1,2'd1,2'd0,7'b0100000,16'h001,16'h008));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h001,16'h008));
      tbl.push_back(mk(0,0,1,2'd0,2'd1,7'b0000000,16'h003,16'h008));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h003,16'h008));
      tbl.push_back(mk(0,0,1,2'd1,2'd1,7'b0100000,16'h003,16'h018));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h003,16'h018));
      tbl.push_back(mk(0,0,1,2'd0,2'd2,7'b0000000,16'h007,16'h018));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b0001001,16'h007,16'h018));
      tbl.push_back(mk(0,0,1,2'd2,2'd2,7'b0001001,16'h007,16'h018));
      // Occupied cell, retries, off-board coordinates
      tbl.push_back(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,0,1,2'd1,2'd1,7'b0000000,16'h010,16'h000));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h010,16'h000));
      tbl.push_back(mk(0,0,1,2'd1,2'd1,7'b1110000,16'h010,16'h000));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h010,16'h000));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b0100000,16'h010,16'h001));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h010,16'h001));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b1010000,16'h010,16'h001));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b1010000,16'h010,16'h001));
      tbl.push_back(mk(0,0,1,2'd2,2'd2,7'b0000000,16'h110,16'h001));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h110,16'h001));
      tbl.push_back(mk(0,0,1,2'd3,2'd0,7'b1110000,16'h110,16'h001));
      tbl.push_back(mk(0,0,1,2'd0,2'd3,7'b1110000,16'h110,16'h001));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h110,16'h001));
      // Draw: X0 O1 X2 O4 X3 O6 X7 O5 X8
      tbl.push_back(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b0000000,16'h001,16'h000));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h001,16'h000));
      tbl.push_back(mk(0,0,1,2'd0,2'd1,7'b0100000,16'h001,16'h002));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h001,16'h002));
      tbl.push_back(mk(0,0,1,2'd0,2'd2,7'b0000000,16'h005,16'h002));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h005,16'h002));
      tbl.push_back(mk(0,0,1,2'd1,2'd1,7'b0100000,16'h005,16'h012));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h005,16'h012));
      tbl.push_back(mk(0,0,1,2'd1,2'd0,7'b0000000,16'h00D,16'h012));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h00D,16'h012));
      tbl.push_back(mk(0,0,1,2'd2,2'd0,7'b0100000,16'h00D,16'h052));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h00D,16'h052));
      tbl.push_back(mk(0,0,1,2'd2,2'd1,7'b0000000,16'h08D,16'h052));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1100000,16'h08D,16'h052));
      tbl.push_back(mk(0,0,1,2'd1,2'd2,7'b0100000,16'h08D,16'h072));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h08D,16'h072));
      tbl.push_back(mk(0,0,1,2'd2,2'd2,7'b0000000,16'h18D,16'h072));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b0000011,16'h18D,16'h072));
      // Restart in CHECK and in TURN with a move presented: move dropped
      tbl.push_back(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,0,1,2'd0,2'd0,7'b0000000,16'h001,16'h000));
      tbl.push_back(mk(0,1,1,2'd1,2'd1,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,1,1,2'd2,2'd2,7'b1000000,16'h000,16'h000));
      tbl.push_back(mk(0,0,0,2'd0,2'd0,7'b1000000,16'h000,16'h000));
      // 4x4, K=3: X anti-diagonal (0,3),(1,2),(2,1)
      tbl.push_back(mk(1,1,0,2'd0,2'd0,7'b1000000,16'h0000,16'h0000));
      tbl.push_back(mk(1,0,1,2'd0,2'd3,7'b0000000,16'h0008,16'h0000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1100000,16'h0008,16'h0000));
      tbl.push_back(mk(1,0,1,2'd3,2'd3,7'b0100000,16'h0008,16'h8000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1000000,16'h0008,16'h8000));
      tbl.push_back(mk(1,0,1,2'd1,2'd2,7'b0000000,16'h0048,16'h8000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1100000,16'h0048,16'h8000));
      tbl.push_back(mk(1,0,1,2'd3,2'd2,7'b0100000,16'h0048,16'hC000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1000000,16'h0048,16'hC000));
      tbl.push_back(mk(1,0,1,2'd2,2'd1,7'b0000000,16'h0248,16'hC000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b0001001,16'h0248,16'hC000));
      // 4x4, K=3: O row (3,0..2)
      tbl.push_back(mk(1,1,0,2'd0,2'd0,7'b1000000,16'h0000,16'h0000));
      tbl.push_back(mk(1,0,1,2'd0,2'd0,7'b0000000,16'h0001,16'h0000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1100000,16'h0001,16'h0000));
      tbl.push_back(mk(1,0,1,2'd3,2'd0,7'b0100000,16'h0001,16'h1000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1000000,16'h0001,16'h1000));
      tbl.push_back(mk(1,0,1,2'd0,2'd2,7'b0000000,16'h0005,16'h1000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1100000,16'h0005,16'h1000));
      tbl.push_back(mk(1,0,1,2'd3,2'd1,7'b0100000,16'h0005,16'h3000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1000000,16'h0005,16'h3000));
      tbl.push_back(mk(1,0,1,2'd1,2'd1,7'b0000000,16'h0025,16'h3000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b1100000,16'h0025,16'h3000));
      tbl.push_back(mk(1,0,1,2'd3,2'd2,7'b0100000,16'h0025,16'h7000));
      tbl.push_back(mk(1,0,0,2'd0,2'd0,7'b0100101,16'h0025,16'h7000));

      // ---------------- reset ----------------
      rst_n      = 1'b0;
      start      = 1'b0;
      move_valid = 1'b0;
      move_row   = 2'd0;
      move_col   = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset3", actual(1'b0), 39'd0);
      check("reset4", actual(1'b1), 39'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], $sformatf("vec%0d", i));
      end

      // ---------------- reset asserted mid-game ----------------
      run_vec(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000), "mid_start");
      run_vec(mk(0,0,1,2'd1,2'd1,7'b0000000,16'h010,16'h000), "mid_move");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst3", actual(1'b0), 39'd0);
      check("async_rst4", actual(1'b1), 39'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // First cycle after release is IDLE: move ignored, no ready
      run_vec(mk(0,0,1,2'd0,2'd0,7'b0000000,16'h000,16'h000), "post_rst_idle");
      run_vec(mk(0,1,0,2'd0,2'd0,7'b1000000,16'h000,16'h000), "post_rst_start");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
